sd_response_collector: RTL and testbench
========================================

SD_RESPONSE_COLLECTOR -- requirements
Module: sd_response_collector

Interface
REQ-001 Parameter MAX_POLL, default 8: max response-poll bytes (Ncr) before timeout.
REQ-002 Parameter BUSY_MAX, default 65535: max busy-poll bytes for R1b before timeout.
REQ-003 clk  input  1  master clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins capture of one response.
REQ-006 resp_type  input  2  0=R1, 1=R3/R7 (R1+4 bytes), 2=R1b, 3=treated as R1; sampled with start.
REQ-007 rx_byte  input  8  byte received from SPI layer; valid only with rx_valid.
REQ-008 rx_valid  input  1  one-cycle strobe; the byte requested by byte_req has completed.
REQ-009 byte_req  output  1  one-cycle pulse; requests the SPI layer to clock one 0xFF byte.
REQ-010 busy  output  1  high from the cycle after start is accepted until done.
REQ-011 done  output  1  one-cycle pulse; capture complete.
REQ-012 timeout  output  1  valid with done; held until next accepted start.
REQ-013 r1  output  8  captured R1 byte; held until next accepted start.
REQ-014 payload  output  32  trailing 4 bytes of R3/R7, MSB-first; held until next accepted start.
REQ-015 r1_error  output  1  |r1[6:1]; valid with done; held.

Function
REQ-016 States SHALL be IDLE, POLL, PAYLOAD, BUSYWAIT, DONE.
REQ-017 IDLE: start=1 SHALL latch resp_type, clear r1/payload/timeout/r1_error, zero counters, enter POLL, and pulse byte_req the next cycle.
REQ-018 start while not IDLE SHALL be ignored.
REQ-019 At most one byte_req SHALL be outstanding; the next byte_req is issued only in the cycle after rx_valid.
REQ-020 rx_valid in IDLE or DONE, or with no request outstanding, SHALL be ignored.
REQ-021 POLL, rx_byte[7]=1: poll count +1; if count reaches MAX_POLL -> r1=8'hFF, timeout=1, DONE; else byte_req next cycle.
REQ-022 POLL, rx_byte[7]=0: latch r1=rx_byte; then R1 -> DONE; R3/R7 -> PAYLOAD unless rx_byte[2]=1 (illegal cmd: R1 only) -> DONE; R1b -> BUSYWAIT.
REQ-023 PAYLOAD: each rx_valid shifts rx_byte into payload[7:0] (payload <= {payload[23:0], rx_byte}); after the 4th byte -> DONE.
REQ-024 BUSYWAIT: rx_byte==8'h00 -> busy count +1, byte_req next cycle; any nonzero byte -> DONE; busy count reaching BUSY_MAX -> timeout=1, DONE.
REQ-025 DONE: done=1 for exactly one cycle, busy=0, then IDLE.
REQ-026 Latency: final rx_valid at cycle M -> done high at cycle M+1; start at cycle N -> byte_req at cycle N+1.
REQ-027 Counters SHALL be wide enough for their parameter; no wrap before the limit compare.
REQ-028 byte_req and done SHALL never be high in the same cycle.

Reset
REQ-029 rst=1 SHALL, on the next edge and regardless of state: state=IDLE, byte_req=0, busy=0, done=0, timeout=0, r1=8'h00, payload=0, r1_error=0, counters=0.
REQ-030 rst asserted mid-capture SHALL abandon the capture; a late rx_valid after reset SHALL be ignored.
REQ-031 start and rst in the same cycle: rst wins; no capture starts.

Verification
REQ-032 R1: start, resp_type=0; bytes FF,FF,01 -> r1=01, r1_error=0, timeout=0, done 1 cycle after 3rd rx_valid, 3 byte_req pulses.
REQ-033 R7: resp_type=1; bytes FF,01,00,00,01,AA -> r1=01, payload=32'h000001AA, 6 byte_req pulses.
REQ-034 R7 illegal: resp_type=1; byte 05 -> r1=05, r1_error=1, payload=0, done after 1 byte, no further byte_req.
REQ-035 Timeout: MAX_POLL=8, all bytes FF -> done after 8th byte, timeout=1, r1=FF; R1b with BUSY_MAX=4, bytes 00,00,00,00,00 -> timeout=1 after 5 bytes (1 R1 + 4 busy).
REQ-036 Reset mid-PAYLOAD after 2 bytes -> next cycle all outputs 0, state IDLE; stray rx_valid ignored; subsequent R1 capture correct.
REQ-037 start pulsed while busy -> ignored; resp_type change while busy has no effect.

Source files
------------

// File: rtl/sd_response_collector.sv
// sd_response_collector
//   Collects one SD-card SPI-mode command response (R1, R3/R7 or R1b) by
//   asking the SPI byte layer for 0xFF bytes one at a time and interpreting
//   what comes back.
//
// Handshake with the SPI byte layer:
//   byte_req is a one-cycle pulse asking for one byte. Exactly one request
//   is outstanding at a time. The layer answers with a one-cycle rx_valid
//   strobe carrying rx_byte. The next byte_req appears in the cycle after
//   that rx_valid. An rx_valid with no request outstanding is dropped.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, resp_type  begin a capture; resp_type 0=R1 1=R3/R7 2=R1b 3=R1
//   rx_byte, rx_valid byte returned by the SPI layer
//   byte_req          request one byte from the SPI layer
//   busy              capture in progress (cycle after start until done)
//   done              one-cycle completion pulse
//   timeout           capture ended on a poll or busy limit
//   r1, payload       captured R1 byte and R3/R7 trailing word (MSB first)
//   r1_error          any error flag set in r1[6:1]
//   state_dbg         current FSM state, for observation only
module sd_response_collector #(
  parameter int MAX_POLL = 8,
  parameter int BUSY_MAX = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  resp_type,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        byte_req,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  r1,
  output logic [31:0] payload,
  output logic        r1_error,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_POLL     = 3'd1,
    S_PAYLOAD  = 3'd2,
    S_BUSYWAIT = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RT_R1  = 2'd0,
    RT_R7  = 2'd1,
    RT_R1B = 2'd2
  } rtype_e;

  // Counters hold values up to and including their limit.
  localparam int PW = $clog2(MAX_POLL + 1);
  localparam int BW = $clog2(BUSY_MAX + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLL - 1);
  localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_MAX - 1);

  state_e          state_q, state_d;
  rtype_e          rtype_q, rtype_d;
  logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
  logic [BW-1:0]   busy_cnt_q, busy_cnt_d;
  logic [1:0]      pay_cnt_q, pay_cnt_d;
  logic            req_out_q, req_out_d;
  logic            byte_req_q, byte_req_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      r1_q, r1_d;
  logic [31:0]     payload_q, payload_d;
  logic            accept;

  // A returned byte only counts while a request is outstanding.
  assign accept = rx_valid && req_out_q;

  always_comb begin
    state_d    = state_q;
    rtype_d    = rtype_q;
    poll_cnt_d = poll_cnt_q;
    busy_cnt_d = busy_cnt_q;
    pay_cnt_d  = pay_cnt_q;
    req_out_d  = req_out_q;
    byte_req_d = 1'b0;
    timeout_d  = timeout_q;
    r1_d       = r1_q;
    payload_d  = payload_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (resp_type)
            2'd1:    rtype_d = RT_R7;
            2'd2:    rtype_d = RT_R1B;
            default: rtype_d = RT_R1;
          endcase
          r1_d       = 8'h00;
          payload_d  = 32'h0;
          timeout_d  = 1'b0;
          poll_cnt_d = '0;
          busy_cnt_d = '0;
          pay_cnt_d  = '0;
          state_d    = S_POLL;
          byte_req_d = 1'b1;
          req_out_d  = 1'b1;
        end
      end

      S_POLL: begin
        if (accept) begin
          req_out_d = 1'b0;
          if (rx_byte[7]) begin
            // Bus still idle (0xFF-like): keep polling up to the Ncr limit.
            poll_cnt_d = poll_cnt_q + 1'b1;
            if (poll_cnt_q == POLL_LAST) begin
              r1_d      = 8'hFF;
              timeout_d = 1'b1;
              state_d   = S_DONE;
            end else begin
              byte_req_d = 1'b1;
              req_out_d  = 1'b1;
            end
          end else begin
            r1_d = rx_byte;
            case (rtype_q)
              RT_R7: begin
                // Illegal-command bit: the card sends R1 only.
                if (rx_byte[2]) begin
                  state_d = S_DONE;
                end else begin
                  state_d    = S_PAYLOAD;
                  byte_req_d = 1'b1;
                  req_out_d  = 1'b1;
                end
              end
              RT_R1B: begin
                state_d    = S_BUSYWAIT;
                byte_req_d = 1'b1;
                req_out_d  = 1'b1;
              end
              default: state_d = S_DONE;
            endcase
          end
        end
      end

      S_PAYLOAD: begin
        if (accept) begin
          req_out_d = 1'b0;
          payload_d = {payload_q[23:0], rx_byte};
          if (pay_cnt_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            pay_cnt_d  = pay_cnt_q + 1'b1;
            byte_req_d = 1'b1;
            req_out_d  = 1'b1;
          end
        end
      end

      S_BUSYWAIT: begin
        if (accept) begin
          req_out_d = 1'b0;
          if (rx_byte != 8'h00) begin
            state_d = S_DONE;
          end else begin
            busy_cnt_d = busy_cnt_q + 1'b1;
            if (busy_cnt_q == BUSY_LAST) begin
              timeout_d = 1'b1;
              state_d   = S_DONE;
            end else begin
              byte_req_d = 1'b1;
              req_out_d  = 1'b1;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rtype_q    <= RT_R1;
      poll_cnt_q <= '0;
      busy_cnt_q <= '0;
      pay_cnt_q  <= '0;
      req_out_q  <= 1'b0;
      byte_req_q <= 1'b0;
      timeout_q  <= 1'b0;
      r1_q       <= 8'h00;
      payload_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      rtype_q    <= rtype_d;
      poll_cnt_q <= poll_cnt_d;
      busy_cnt_q <= busy_cnt_d;
      pay_cnt_q  <= pay_cnt_d;
      req_out_q  <= req_out_d;
      byte_req_q <= byte_req_d;
      timeout_q  <= timeout_d;
      r1_q       <= r1_d;
      payload_q  <= payload_d;
    end
  end

  assign byte_req  = byte_req_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign timeout   = timeout_q;
  assign r1        = r1_q;
  assign payload   = payload_q;
  assign r1_error  = |r1_q[6:1];
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sd_response_collector.sv
module tb_sd_response_collector;

  localparam int MAX_POLL = 8;
  localparam int BUSY_MAX = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  resp_type;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        byte_req;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [7:0]  r1;
  logic [31:0] payload;
  logic        r1_error;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  sd_response_collector #(
    .MAX_POLL(MAX_POLL),
    .BUSY_MAX(BUSY_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .resp_type(resp_type),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .byte_req(byte_req),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .r1(r1),
    .payload(payload),
    .r1_error(r1_error),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  stim_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_r1;
  logic [31:0] exp_payload;
  logic        exp_timeout;
  int          exp_used;

  typedef struct {
    logic [1:0]   rt;
    int           n;
    logic [127:0] bytes;
    logic [7:0]   r1;
    logic [31:0]  pay;
    logic         to;
    logic         err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Wait for a request, optionally disturb start/resp_type while waiting,
  // then return the byte. Extra request pulses are counted so they show up
  // in the request total.
  task automatic feed_byte(input logic [7:0] b, input bit noise, inout int reqs, output bit ok);
    int w;
    int d;
    w = 0;
    while (!byte_req && !done && w < 20) begin
      tick();
      w++;
    end
    ok = byte_req;
    if (!ok) return;
    reqs++;
    d = $urandom_range(0, 2);
    for (int k = 0; k < d; k++) begin
      if (noise) begin
        start     = 1'($urandom_range(0, 1));
        resp_type = 2'($urandom_range(0, 3));
      end
      tick();
      if (byte_req) reqs++;
    end
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_txn(input logic [1:0] rt, input int used, input bit noise, output int reqs);
    bit ok;
    reqs = 0;
    start = 1'b1;
    resp_type = rt;
    tick();
    start = 1'b0;
    check("req_after_start", byte_req, 1);
    check("busy_after_start", busy, 1);
    for (int i = 0; i < used; i++) begin
      feed_byte(stim_q[i], noise, reqs, ok);
      if (!ok) begin
        check("byte_req_wait", byte_req, 1);
        do_reset();
        return;
      end
    end
    check("done_pulse", done, 1);
    check("no_req_with_done", byte_req, 0);
    check("busy_in_done", busy, 0);
    tick();
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic load_vec(input vec_t v);
    stim_q.delete();
    for (int i = 0; i < v.n; i++) stim_q.push_back(v.bytes[8*(v.n-1-i) +: 8]);
  endtask

  // ---------------- reference model ----------------
  // Scans the byte stream the way a card response reads: skip idle bytes
  // (bit 7 set) up to the poll limit, take the first other byte as R1, then
  // four payload bytes for a legal R3/R7 or a zero-run for R1b.
  task automatic model(input logic [1:0] rt);
    int found;
    int zeros;
    found = -1;
    exp_r1 = 8'hFF; exp_payload = 32'h0; exp_timeout = 1'b1; exp_used = MAX_POLL;
    for (int k = 0; k < MAX_POLL; k++) begin
      if (found < 0 && k < stim_q.size() && !stim_q[k][7]) found = k;
    end
    if (found >= 0) begin
      exp_r1 = stim_q[found];
      exp_timeout = 1'b0;
      exp_used = found + 1;
      if (rt == 2'd1 && !exp_r1[2]) begin
        exp_q.delete();
        for (int j = 0; j < 4; j++) exp_q.push_back(stim_q[exp_used + j]);
        exp_payload = 0;
        foreach (exp_q[j]) exp_payload = exp_payload * 256 + 32'(exp_q[j]);
        exp_used += 4;
      end else if (rt == 2'd2) begin
        zeros = 0;
        while (exp_used < stim_q.size()) begin
          if (stim_q[exp_used] != 8'h00) begin
            exp_used++;
            break;
          end
          exp_used++;
          zeros++;
          if (zeros == BUSY_MAX) begin
            exp_timeout = 1'b1;
            break;
          end
        end
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int   reqs;
    bit   ok;
    int   p;
    int   z;
    logic [7:0] rb;
    logic [1:0] rt;

    vecs[0] = '{rt:2'd0, n:3,  bytes:128'hFFFF01,                   r1:8'h01, pay:32'h0,        to:1'b0, err:1'b0};
    vecs[1] = '{rt:2'd1, n:6,  bytes:128'hFF01000001AA,             r1:8'h01, pay:32'h000001AA, to:1'b0, err:1'b0};
    vecs[2] = '{rt:2'd1, n:1,  bytes:128'h05,                       r1:8'h05, pay:32'h0,        to:1'b0, err:1'b1};
    vecs[3] = '{rt:2'd0, n:8,  bytes:128'hFFFFFFFFFFFFFFFF,         r1:8'hFF, pay:32'h0,        to:1'b1, err:1'b1};
    vecs[4] = '{rt:2'd2, n:5,  bytes:128'h0000000000,               r1:8'h00, pay:32'h0,        to:1'b1, err:1'b0};
    vecs[5] = '{rt:2'd2, n:3,  bytes:128'h0000FF,                   r1:8'h00, pay:32'h0,        to:1'b0, err:1'b0};
    vecs[6] = '{rt:2'd3, n:2,  bytes:128'hFF40,                     r1:8'h40, pay:32'h0,        to:1'b0, err:1'b1};
    vecs[7] = '{rt:2'd1, n:12, bytes:128'hFFFFFFFFFFFFFF0012345678, r1:8'h00, pay:32'h12345678, to:1'b0, err:1'b0};

    rst = 1'b1; start = 1'b0; resp_type = 2'd0; rx_byte = 8'h00; rx_valid = 1'b0;
    repeat (3) tick();
    check("rst_byte_req", byte_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_r1", r1, 0);
    check("rst_payload", payload, 0);
    check("rst_r1_error", r1_error, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    tick();

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      load_vec(vecs[i]);
      run_txn(vecs[i].rt, vecs[i].n, 1'b0, reqs);
      check("tbl_r1", r1, vecs[i].r1);
      check("tbl_payload", payload, vecs[i].pay);
      check("tbl_timeout", timeout, vecs[i].to);
      check("tbl_r1_error", r1_error, vecs[i].err);
      check("tbl_reqs", reqs, vecs[i].n);
      tick();
    end

    // Reset in the middle of a payload, then a stray byte.
    stim_q = '{8'h01, 8'h11, 8'h22};
    reqs = 0;
    start = 1'b1; resp_type = 2'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) feed_byte(stim_q[i], 1'b0, reqs, ok);
    check("mid_payload_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_byte_req", byte_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_r1", r1, 0);
    check("midrst_payload", payload, 0);
    check("midrst_state", state_dbg, 0);
    rx_valid = 1'b1; rx_byte = 8'h00;
    tick();
    rx_valid = 1'b0;
    check("stray_byte_req", byte_req, 0);
    check("stray_busy", busy, 0);
    check("stray_r1", r1, 0);
    tick();
    check("stray_done", done, 0);

    // Start and reset together: reset wins.
    rst = 1'b1; start = 1'b1; resp_type = 2'd0;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rststart_byte_req", byte_req, 0);
    check("rststart_busy", busy, 0);
    tick();
    check("rststart_byte_req2", byte_req, 0);
    check("rststart_busy2", busy, 0);

    // Capture after the reset cases.
    stim_q = '{8'hFF, 8'h01};
    run_txn(2'd0, 2, 1'b0, reqs);
    check("post_rst_r1", r1, 8'h01);
    check("post_rst_reqs", reqs, 2);
    tick();

    // Randomised transactions against the model, with start/resp_type
    // disturbed while the capture is busy.
    for (int t = 0; t < 40; t++) begin
      rt = 2'($urandom_range(0, 3));
      stim_q.delete();
      p = $urandom_range(0, 9);
      for (int i = 0; i < p; i++) stim_q.push_back(8'h80 | 8'($urandom_range(0, 127)));
      rb = 8'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) rb = rb & 8'hFB;
      stim_q.push_back(rb);
      if (rt == 2'd2) begin
        z = $urandom_range(0, 5);
        for (int i = 0; i < z; i++) stim_q.push_back(8'h00);
        stim_q.push_back(8'($urandom_range(1, 255)));
      end else begin
        for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom_range(0, 255)));
      end
      model(rt);
      run_txn(rt, exp_used, 1'b1, reqs);
      check("rnd_r1", r1, exp_r1);
      check("rnd_payload", payload, exp_payload);
      check("rnd_timeout", timeout, exp_timeout);
      check("rnd_r1_error", r1_error, ((exp_r1 & 8'h7E) != 8'h00));
      check("rnd_reqs", reqs, exp_used);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
